qr_axis_matrix_loader: RTL and testbench
========================================

Name: qr_axis_matrix_loader

Overview:
- Input stage of the QR-CORDIC accelerator inside yolo_top, between the AXI-Stream MM2S slave port and the CORDIC rotation array.
- Collects one ROWS x COLS matrix of signed fixed-point elements, one row per 64-bit beat, into a two-bank ping-pong buffer.
- Replays each completed matrix row-by-row to the core over a valid/ready interface, so the DMA can load matrix N+1 while the core drains matrix N.

Parameters:
- TBITS, 64, stream data width; also the width of one matrix row.
- TBYTE, 8, TKEEP width (TBITS/8).
- ELEM_W, 16, element width; COLS = TBITS/ELEM_W = 4.
- ROWS, 8, rows per matrix (beats per frame).

Ports:
- aclk  in  1  single clock for stream and core sides.
- aresetn  in  1  asynchronous, active-low reset.
- S_AXIS_MM2S_TVALID  in  1  input beat valid.
- S_AXIS_MM2S_TREADY  out  1  loader can accept a beat.
- S_AXIS_MM2S_TDATA  in  TBITS  one row; element c at bits [c*ELEM_W +: ELEM_W].
- S_AXIS_MM2S_TKEEP  in  TBYTE  byte enables; masked bytes are stored as 0.
- S_AXIS_MM2S_TLAST  in  1  last beat of a matrix frame.
- row_valid  out  1  row presented to the core.
- row_ready  in  1  core accepts the row.
- row_data  out  TBITS  current row of the draining bank.
- row_idx  out  3  row index 0..ROWS-1.
- row_last  out  1  row_idx == ROWS-1.
- err_clr  in  1  synchronous clear of the sticky error flags.
- err_short  out  1  sticky: TLAST arrived before row ROWS-1.
- err_long  out  1  sticky: row ROWS-1 accepted without TLAST.

Behaviour:
- Storage: buf[2][ROWS] x TBITS. State registers:
  - full[1:0]
  - wr_bank, wr_row
  - rd_bank, rd_row
- Reset values:
  - full=0, all pointers 0, err flags 0.
  - TREADY=0, row_valid=0.
  - row_data is don't-care while row_valid=0; the bench must not check it.
- S_AXIS_MM2S_TREADY = !full[wr_bank]. It is combinational from registers only and never depends on TVALID.
- Beat accept (TVALID & TREADY):
  - buf[wr_bank][wr_row] <= TDATA with bytes where TKEEP=0 forced to 8'h00.
  - wr_row increments.
- Frame completion, on either:
  - an accepted beat with TLAST, or
  - an accepted beat at wr_row==ROWS-1.
  On completion: full[wr_bank]<=1, wr_bank toggles, wr_row<=0.
- Early TLAST (wr_row<ROWS-1):
  - in the same cycle, rows wr_row+1..ROWS-1 of that bank are written 0;
  - err_short<=1.
- Missing TLAST at wr_row==ROWS-1: err_long<=1. The next beat starts a new matrix; there is no resync hunting.
- Drain side:
  - row_valid = full[rd_bank].
  - row_data = buf[rd_bank][rd_row]; combinational read, stable while row_valid & !row_ready.
  - On handshake rd_row increments.
  - On handshake with row_last: full[rd_bank]<=0, rd_bank toggles, rd_row<=0.
- Latency: row_valid rises in the cycle after the completing beat is accepted, so row 0 is available at accept+1.
- Throughput: 1 row/cycle on each side. The freed bank's TREADY rises the cycle after the row_last handshake.
- Simultaneous events:
  - Completion of one bank and release of the other in the same cycle are both applied.
  - full bits are set and cleared independently per bank.
- Both banks full: TREADY=0 until a drain completes. No beat is dropped and no data is overwritten.
- err_clr: clears both flags. If err_clr coincides with a new error event, the error set wins.
- Reset mid-frame (aresetn low): discards all partial and full banks immediately; the buffer contents need not be cleared.

Decomposition:
- Shared package qr_pkg holds:
  - ELEM_W, COLS, ROWS, ROW_IDX_W=$clog2(ROWS);
  - a function keep_mask(TKEEP) returning the TBITS byte-expanded mask.
- Natural sub-module: qr_row_bank, holding one ROWS x TBITS bank with a write port, a zero-tail-fill port and a read mux.
  - Instantiated twice.
  - Pointer and full logic stay in the top.

Test Plan:
- Nominal frame: 8 beats TDATA=64'h0001_0002_0003_0004 + i*64'h0010_0010_0010_0010, TKEEP=8'hFF, TLAST on beat 7, row_ready=1 → row_valid at accept+1; row_data sequence equals the input; row_idx 0..7; row_last only on idx 7; no error flags.
- Ping-pong backpressure: three back-to-back frames with row_ready=0 → TREADY drops after beat 16 and stays 0. Raise row_ready → frame 1 drains; TREADY returns one cycle after its row_last; frame 3 is loaded intact.
- Short frame: TLAST on beat 4 (idx 4) → err_short=1; rows 5..7 drain as 64'h0; the next frame starts at row 0 in the other bank.
- Long frame: 8 beats without TLAST, then 8 beats with TLAST → err_long=1 after beat 7; two matrices are drained. err_clr pulse → flags 0.
- TKEEP mask: beat 0 TDATA=64'hFFFF_FFFF_FFFF_FFFF, TKEEP=8'h0F → row 0 reads 64'h0000_0000_FFFF_FFFF.
- Reset mid-frame: assert aresetn=0 after beat 3 → row_valid=0, TREADY=0 during reset. After release, a fresh 8-beat frame drains correctly with no residual rows.

Source files
------------

// File: rtl/qr_axis_matrix_loader_pkg.sv
// Shared types and constants for the QR matrix loader.
// Row geometry, index width and TKEEP byte-mask helper.
package qr_pkg;
  localparam int TBITS     = 64;
  localparam int TBYTE     = TBITS / 8;
  localparam int ELEM_W    = 16;
  localparam int COLS      = TBITS / ELEM_W;
  localparam int ROWS      = 8;
  localparam int ROW_IDX_W = $clog2(ROWS);

  typedef logic [TBITS-1:0]     row_t;
  typedef logic [ROW_IDX_W-1:0] ridx_t;

  localparam ridx_t LAST_ROW = ridx_t'(ROWS - 1);

  function automatic row_t keep_mask(input logic [TBYTE-1:0] keep);
    row_t m;
    for (int b = 0; b < TBYTE; b++)
      m[b*8 +: 8] = {8{keep[b]}};
    return m;
  endfunction
endpackage

// File: rtl/qr_axis_matrix_loader_if.sv
// Stream-in and row-out handshake bundle of the loader.
// slave is the loader's view, master the DMA/core view.
interface qr_axis_matrix_loader_if;
  import qr_pkg::*;

  logic              S_AXIS_MM2S_TVALID;
  logic              S_AXIS_MM2S_TREADY;
  row_t              S_AXIS_MM2S_TDATA;
  logic [TBYTE-1:0]  S_AXIS_MM2S_TKEEP;
  logic              S_AXIS_MM2S_TLAST;
  logic              row_valid;
  logic              row_ready;
  row_t              row_data;
  ridx_t             row_idx;
  logic              row_last;

  modport slave (
    input  S_AXIS_MM2S_TVALID,
    input  S_AXIS_MM2S_TDATA,
    input  S_AXIS_MM2S_TKEEP,
    input  S_AXIS_MM2S_TLAST,
    input  row_ready,
    output S_AXIS_MM2S_TREADY,
    output row_valid,
    output row_data,
    output row_idx,
    output row_last
  );

  modport master (
    output S_AXIS_MM2S_TVALID,
    output S_AXIS_MM2S_TDATA,
    output S_AXIS_MM2S_TKEEP,
    output S_AXIS_MM2S_TLAST,
    output row_ready,
    input  S_AXIS_MM2S_TREADY,
    input  row_valid,
    input  row_data,
    input  row_idx,
    input  row_last
  );
endinterface

// File: rtl/qr_row_bank.sv
// One ROWS x TBITS matrix bank.
// Write port, zero-fill of rows above waddr, async read mux.
module qr_row_bank
  import qr_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  ridx_t waddr,
  input  row_t  wdata,
  input  logic  zf,
  input  ridx_t raddr,
  output row_t  rdata
);

  row_t mem [ROWS];

  // Store a row; on early TLAST also clear the unwritten tail.
  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++)
      if (zf && (ridx_t'(r) > waddr))
        mem[r] <= '0;
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qr_axis_matrix_loader.sv
// Ping-pong matrix loader: AXIS beats in, matrix rows out.
// One bank fills while the other drains to the CORDIC core.
module qr_axis_matrix_loader
  import qr_pkg::*;
(
  input  logic                     aclk,
  input  logic                     aresetn,
  qr_axis_matrix_loader_if.slave   s,
  input  logic                     err_clr,
  output logic                     err_short,
  output logic                     err_long
);

  logic [1:0] full;
  logic       wr_bank;
  logic       rd_bank;
  logic       run_q;
  ridx_t      wr_row;
  ridx_t      rd_row;
  row_t       wdata;
  row_t       rdata [2];

  logic acc;
  logic last_row;
  logic done;
  logic early;
  logic missing;
  logic rd_hs;
  logic rd_done;

  assign s.S_AXIS_MM2S_TREADY = run_q & ~full[wr_bank];

  assign acc      = s.S_AXIS_MM2S_TVALID & s.S_AXIS_MM2S_TREADY;
  assign last_row = (wr_row == LAST_ROW);
  assign done     = acc & (s.S_AXIS_MM2S_TLAST | last_row);
  assign early    = acc & s.S_AXIS_MM2S_TLAST & ~last_row;
  assign missing  = acc & ~s.S_AXIS_MM2S_TLAST & last_row;
  assign wdata    = s.S_AXIS_MM2S_TDATA & keep_mask(s.S_AXIS_MM2S_TKEEP);

  assign s.row_valid = full[rd_bank];
  assign s.row_data  = rdata[rd_bank];
  assign s.row_idx   = rd_row;
  assign s.row_last  = (rd_row == LAST_ROW);

  assign rd_hs   = s.row_valid & s.row_ready;
  assign rd_done = rd_hs & s.row_last;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    qr_row_bank u_bank (
      .clk   (aclk),
      .we    (acc && (wr_bank == 1'(b))),
      .waddr (wr_row),
      .wdata (wdata),
      .zf    (early && (wr_bank == 1'(b))),
      .raddr (rd_row),
      .rdata (rdata[b])
    );
  end

  // Write and read pointers; run_q holds TREADY low through reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q   <= 1'b0;
      wr_bank <= 1'b0;
      wr_row  <= '0;
      rd_bank <= 1'b0;
      rd_row  <= '0;
    end else begin
      run_q <= 1'b1;
      if (done) begin
        wr_row  <= '0;
        wr_bank <= ~wr_bank;
      end else if (acc) begin
        wr_row <= wr_row + 1'b1;
      end
      if (rd_done) begin
        rd_row  <= '0;
        rd_bank <= ~rd_bank;
      end else if (rd_hs) begin
        rd_row <= rd_row + 1'b1;
      end
    end
  end

  // Per-bank full bits: set on frame completion, cleared on drain.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (done && (wr_bank == 1'(b)))
          full[b] <= 1'b1;
        else if (rd_done && (rd_bank == 1'(b)))
          full[b] <= 1'b0;
      end
    end
  end

  // Sticky framing errors; a new event beats a clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      err_short <= early   | (err_short & ~err_clr);
      err_long  <= missing | (err_long  & ~err_clr);
    end
  end

endmodule

// File: tb/tb_qr_axis_matrix_loader.sv
// Self-checking bench for the QR matrix loader.
// Frame-level model of the buffer plus literal row checks.
module tb_qr_axis_matrix_loader;
  import qr_pkg::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic err_clr = 1'b0;
  logic err_short;
  logic err_long;

  qr_axis_matrix_loader_if bus ();

  qr_axis_matrix_loader dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s         (bus.slave),
    .err_clr   (err_clr),
    .err_short (err_short),
    .err_long  (err_long)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  typedef struct {
    row_t data;
    int   idx;
  } erow_t;

  erow_t rowq [$];
  row_t  cur [ROWS];
  int    cur_n = 0;
  bit    m_short = 0;
  bit    m_long = 0;
  int    since = 0;
  row_t  cap [$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic row_t tb_mask(row_t d, logic [7:0] k);
    row_t r = d;
    for (int b = 0; b < 8; b++)
      if (!k[b]) r[b*8 +: 8] = 8'h00;
    return r;
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) since <= 0;
    else if (since < 2) since <= since + 1;
  end

  bit exp_rdy, acc, hs, set_s, set_l;
  int held;
  erow_t e;

  // Compare against the model, then advance it to the next edge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_row_valid", bus.row_valid, 0);
      chk("rst_tready", bus.S_AXIS_MM2S_TREADY, 0);
      chk("rst_err_short", err_short, 0);
      chk("rst_err_long", err_long, 0);
      rowq.delete();
      cur_n = 0;
      m_short = 0;
      m_long = 0;
    end else begin
      held = (rowq.size() + ROWS - 1) / ROWS;
      exp_rdy = (since > 0) && (held < 2);
      chk("tready", bus.S_AXIS_MM2S_TREADY, exp_rdy);
      chk("row_valid", bus.row_valid, rowq.size() > 0);
      if (rowq.size() > 0 && bus.row_valid) begin
        chk("row_data", bus.row_data, rowq[0].data);
        chk("row_idx", bus.row_idx, rowq[0].idx);
        chk("row_last", bus.row_last, rowq[0].idx == ROWS - 1);
      end
      chk("err_short", err_short, m_short);
      chk("err_long", err_long, m_long);
      hs = (rowq.size() > 0) && bus.row_ready;
      if (hs && bus.row_valid) cap.push_back(bus.row_data);
      acc = exp_rdy && bus.S_AXIS_MM2S_TVALID;
      if (hs) void'(rowq.pop_front());
      set_s = 0;
      set_l = 0;
      if (acc) begin
        cur[cur_n] = tb_mask(bus.S_AXIS_MM2S_TDATA, bus.S_AXIS_MM2S_TKEEP);
        if (bus.S_AXIS_MM2S_TLAST || cur_n == ROWS - 1) begin
          set_s = bus.S_AXIS_MM2S_TLAST && (cur_n < ROWS - 1);
          set_l = !bus.S_AXIS_MM2S_TLAST;
          for (int r = 0; r < ROWS; r++) begin
            e.data = (r <= cur_n) ? cur[r] : '0;
            e.idx = r;
            rowq.push_back(e);
          end
          cur_n = 0;
        end else begin
          cur_n++;
        end
      end
      if (set_s) m_short = 1;
      else if (err_clr) m_short = 0;
      if (set_l) m_long = 1;
      else if (err_clr) m_long = 0;
    end
  end

  task automatic send(row_t d, logic [7:0] k, logic l);
    int n = 0;
    bit a = 0;
    bus.S_AXIS_MM2S_TDATA = d;
    bus.S_AXIS_MM2S_TKEEP = k;
    bus.S_AXIS_MM2S_TLAST = l;
    bus.S_AXIS_MM2S_TVALID = 1'b1;
    do begin
      @(negedge aclk);
      a = bus.S_AXIS_MM2S_TREADY;
      @(posedge aclk);
      n++;
    end while (!a && n < 400);
    if (!a) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got tready=0 want accept within 400");
    end
    #1 bus.S_AXIS_MM2S_TVALID = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rowq.size() > 0 || bus.row_valid) && n < 300) begin
      @(posedge aclk);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL drain_timeout: got %0d rows left want 0", rowq.size());
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge aclk);
    #1 err_clr = 1'b1;
    @(posedge aclk);
    #1 err_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.S_AXIS_MM2S_TVALID = 1'b0;
    bus.S_AXIS_MM2S_TDATA = '0;
    bus.S_AXIS_MM2S_TKEEP = '0;
    bus.S_AXIS_MM2S_TLAST = 1'b0;
    bus.row_ready = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // nominal frame
    bus.row_ready = 1'b1;
    cap.delete();
    for (int i = 0; i < 8; i++)
      send(64'h0001_0002_0003_0004 + 64'(i) * 64'h0010_0010_0010_0010,
           8'hFF, i == 7);
    wait_drain();
    chk("nom_cnt", cap.size(), 8);
    chk("nom_row0", cap[0], 64'h0001_0002_0003_0004);
    chk("nom_row3", cap[3], 64'h0031_0032_0033_0034);
    chk("nom_row7", cap[7], 64'h0071_0072_0073_0074);
    chk("nom_err", {err_short, err_long}, 2'b00);

    // ping-pong backpressure
    bus.row_ready = 1'b0;
    cap.delete();
    fork
      begin
        for (int f = 0; f < 3; f++)
          for (int i = 0; i < 8; i++)
            send(64'h1000_0000_0000_0000 * 64'(f + 1) + 64'(i),
                 8'hFF, i == 7);
      end
      begin
        repeat (40) @(posedge aclk);
        @(negedge aclk);
        chk("pp_tready_low", bus.S_AXIS_MM2S_TREADY, 0);
        chk("pp_valid_high", bus.row_valid, 1);
        @(posedge aclk);
        #1 bus.row_ready = 1'b1;
      end
    join
    wait_drain();
    chk("pp_cnt", cap.size(), 24);
    chk("pp_row0", cap[0], 64'h1000_0000_0000_0000);
    chk("pp_row16", cap[16], 64'h3000_0000_0000_0000);
    chk("pp_row23", cap[23], 64'h3000_0000_0000_0007);

    // short frame then normal frame
    cap.delete();
    for (int i = 0; i < 5; i++)
      send(64'h5555_0000_0000_0000 + 64'(i), 8'hFF, i == 4);
    for (int i = 0; i < 8; i++)
      send(64'h6666_0000_0000_0000 + 64'(i), 8'hFF, i == 7);
    wait_drain();
    chk("short_cnt", cap.size(), 16);
    chk("short_row4", cap[4], 64'h5555_0000_0000_0004);
    chk("short_row5", cap[5], 64'h0);
    chk("short_row7", cap[7], 64'h0);
    chk("short_next0", cap[8], 64'h6666_0000_0000_0000);
    chk("short_flag", err_short, 1);
    chk("short_nolong", err_long, 0);
    pulse_clr();
    chk("short_clr", err_short, 0);

    // long frame: 8 beats without TLAST then 8 with
    cap.delete();
    for (int i = 0; i < 8; i++)
      send(64'h7777_0000_0000_0000 + 64'(i), 8'hFF, 1'b0);
    chk("long_flag", err_long, 1);
    for (int i = 8; i < 16; i++)
      send(64'h7777_0000_0000_0000 + 64'(i), 8'hFF, i == 15);
    wait_drain();
    chk("long_cnt", cap.size(), 16);
    chk("long_row8", cap[8], 64'h7777_0000_0000_0008);
    pulse_clr();
    chk("long_clr", {err_short, err_long}, 2'b00);

    // TKEEP masking
    cap.delete();
    send(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0);
    send(64'h1122_3344_5566_7788, 8'hF0, 1'b0);
    send(64'h1122_3344_5566_7788, 8'h81, 1'b0);
    for (int i = 3; i < 8; i++)
      send(64'h0BAD_0000_0000_0000 + 64'(i), 8'hFF, i == 7);
    wait_drain();
    chk("keep_row0", cap[0], 64'h0000_0000_FFFF_FFFF);
    chk("keep_row1", cap[1], 64'h1122_3344_0000_0000);
    chk("keep_row2", cap[2], 64'h1100_0000_0000_0088);

    // reset mid-frame
    cap.delete();
    for (int i = 0; i < 4; i++)
      send(64'h9999_0000_0000_0000 + 64'(i), 8'hFF, 1'b0);
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    for (int i = 0; i < 8; i++)
      send(64'hABCD_0000_0000_0000 + 64'(i), 8'hFF, i == 7);
    wait_drain();
    chk("rst_cnt", cap.size(), 8);
    chk("rst_row0", cap[0], 64'hABCD_0000_0000_0000);
    chk("rst_row7", cap[7], 64'hABCD_0000_0000_0007);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
